alu_issue_ctrl: RTL and testbench

- Sequential front end that drives the ALU's A/B/Control interface and consumes its Out/ZeroFlag.
- Accepts decoded MIPS operation requests (ALUOp + funct) over a valid/ready handshake and translates them to the 4-bit ALU control code.
- Holds operands stable for an operation-dependent latency (MUL/DIV multicycle), captures the result, and returns it over a valid/ready response channel.
- Sits between the multicycle datapath controller and the ALU.

---
 rtl/alu_issue_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue front end between the multicycle datapath controller
// and the ALU. It accepts decoded MIPS requests (ALUOp + funct) and translates
// them to the 4-bit ALU control code. It holds the operands stable for an
// operation-dependent number of cycles, captures the result, and returns it
// over a valid/ready response channel.
//
// Optional build macro: ALU_ISSUE_DIVZERO_CHECK_EN. When defined, a DIV request
// with operand B equal to zero is rejected as illegal and the ALU is not issued.
module alu_issue_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_MUL = 4'b0011;
  localparam logic [3:0] CTL_DIV = 4'b0100;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [3:0]         alu_ctl_q, alu_ctl_d;
  logic [31:0]        result_q, result_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [3:0]         dec_code;
  logic               dec_illegal;
  logic [CNT_W-1:0]   dec_lat;

  // Translate ALUOp/funct to the ALU control code and flag unsupported ops.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_code    = CTL_ADD;
    dec_illegal = 1'b0;
    unique case (req_aluop)
      2'b00: dec_code = CTL_ADD;
      2'b01: dec_code = CTL_SUB;
      2'b10: begin
        unique case (req_funct)
          6'b100000: dec_code = CTL_ADD;
          6'b100010: dec_code = CTL_SUB;
          6'b100100: dec_code = CTL_AND;
          6'b100101: dec_code = CTL_OR;
          6'b101010: dec_code = CTL_SLT;
          6'b011000: dec_code = CTL_MUL;
          6'b011010: dec_code = CTL_DIV;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
    if (!dec_illegal && dec_code == CTL_DIV && req_b == 32'd0) begin
      dec_illegal = 1'b1;
    end
`endif
  end

  // Number of EXEC cycles the operands are held for the decoded operation.
  always_comb begin
    dec_lat = CNT_W'(1);
    if (dec_code == CTL_MUL) begin
      dec_lat = CNT_W'(MUL_LAT);
    end else if (dec_code == CTL_DIV) begin
      dec_lat = CNT_W'(DIV_LAT);
    end
  end

  // Next-state, operand issue and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_ctl_d = alu_ctl_q;
    result_d  = result_q;
    zero_d    = zero_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_illegal) begin
            result_d = 32'd0;
            zero_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_ctl_d = dec_code;
            cnt_d     = dec_lat;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          result_d = alu_out;
          err_d    = 1'b0;
          // Subtraction trusts the ALU's own zero flag; everything else is
          // judged on the captured value.
          zero_d   = (alu_ctl_q == CTL_SUB) ? alu_zero : (alu_out == 32'd0);
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_ctl_q <= CTL_ADD;
      result_q  <= 32'd0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. A small behavioural ALU answers the
// issued operands; zero_inv lets a step corrupt the ALU zero flag so the
// response zero-flag source can be told apart. Expected values are hand-derived.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic        zero_inv;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_ctrl #(.MUL_LAT(2), .DIV_LAT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_aluop   (req_aluop),
    .req_funct   (req_funct),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU driven by the issued operands.
  always_comb begin
    alu_out = 32'd0;
    case (alu_control)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0011: alu_out = alu_a * alu_b;
      4'b0100: alu_out = (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0) ^ zero_inv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one request, then follow it to its response. exp_lat counts clock
  // edges from the accept edge until rsp_valid is seen (0 for an illegal op).
  task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [3:0] exp_ctl, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err);
    int n;
    check({tag, ".req_ready_pre"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_aluop = aluop;
    req_funct = funct;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      check({tag, ".exec_ctl"}, {28'd0, alu_control}, {28'd0, exp_ctl});
      check({tag, ".exec_ready"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".ctl"}, {28'd0, alu_control}, {28'd0, exp_ctl});
    check({tag, ".result"}, rsp_result, exp_res);
    check({tag, ".zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
    check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  // Complete the response handshake and confirm return to IDLE.
  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_aluop = 2'b00;
    req_funct = 6'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b0;
    zero_inv  = 1'b0;

    // Reset state.
    #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.alu_ctl", {28'd0, alu_control}, 32'h2);
    check("rst.alu_a", alu_a, 32'd0);
    check("rst.alu_b", alu_b, 32'd0);
    check("rst.result", rsp_result, 32'd0);
    check("rst.zero", {31'd0, rsp_zero}, 32'd0);
    check("rst.err", {31'd0, rsp_err}, 32'd0);
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // SUB via funct, equal operands: zero result, ALU zero flag is 1.
    run_op("sub_eq", 2'b10, 6'b100010, 32'd5, 32'd5, 1, 4'b0110, 32'd0, 1'b1, 1'b0);
    consume("sub_eq");

    // MUL: control held for two cycles.
    run_op("mul", 2'b10, 6'b011000, 32'd6, 32'd7, 2, 4'b0011, 32'd42, 1'b0, 1'b0);
    consume("mul");

    // SLT with consumer stalling five cycles.
    run_op("slt", 2'b10, 6'b101010, 32'd3, 32'd9, 1, 4'b0111, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("slt.hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("slt.hold_result", rsp_result, 32'd1);
      check("slt.hold_ready", {31'd0, req_ready}, 32'd0);
    end
    consume("slt");

    // Illegal aluop: immediate error response, ALU outputs untouched.
    run_op("ill_op", 2'b11, 6'b100000, 32'd77, 32'd88, 0, 4'b0111, 32'd0, 1'b0, 1'b1);
    check("ill_op.alu_a", alu_a, 32'd3);
    check("ill_op.alu_b", alu_b, 32'd9);
    consume("ill_op");

    // Illegal funct under R-type.
    run_op("ill_fn", 2'b10, 6'b000000, 32'd1, 32'd2, 0, 4'b0111, 32'd0, 1'b0, 1'b1);
    consume("ill_fn");

    // Plain add via aluop 00.
    run_op("add", 2'b00, 6'b000000, 32'd100, 32'd23, 1, 4'b0010, 32'd123, 1'b0, 1'b0);
    check("add.alu_a", alu_a, 32'd100);
    consume("add");

    // OR via funct.
    run_op("or", 2'b10, 6'b100101, 32'h5, 32'hA, 1, 4'b0001, 32'hF, 1'b0, 1'b0);
    consume("or");

    // AND with a lying ALU zero flag: zero must come from the result value.
    zero_inv = 1'b1;
    run_op("and", 2'b10, 6'b100100, 32'hFF, 32'h0F, 1, 4'b0000, 32'h0F, 1'b0, 1'b0);
    consume("and");

    // SUB via aluop 01 with a lying ALU zero flag: zero follows the ALU flag.
    run_op("sub_flag", 2'b01, 6'b000000, 32'd5, 32'd3, 1, 4'b0110, 32'd2, 1'b1, 1'b0);
    consume("sub_flag");
    zero_inv = 1'b0;

    // Divide by zero.
`ifdef ALU_ISSUE_DIVZERO_CHECK_EN
    run_op("div0", 2'b10, 6'b011010, 32'd10, 32'd0, 0, 4'b0110, 32'd0, 1'b0, 1'b1);
`else
    run_op("div0", 2'b10, 6'b011010, 32'd10, 32'd0, 4, 4'b0100, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif
    consume("div0");

    // Ordinary divide.
    run_op("div", 2'b10, 6'b011010, 32'd100, 32'd7, 4, 4'b0100, 32'd14, 1'b0, 1'b0);
    consume("div");

    // Reset in the middle of a DIV: operation abandoned, no response.
    check("abort.req_ready_pre", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_aluop = 2'b10;
    req_funct = 6'b011010;
    req_a     = 32'd50;
    req_b     = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort.req_ready", {31'd0, req_ready}, 32'd1);
    check("abort.alu_ctl", {28'd0, alu_control}, 32'h2);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort.no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
